// File: rtl/demux1to8_pkg.sv
// Shared routing constants and slot state encoding for the result/dispatch path.
package demux1to8_pkg;

    // Default payload width for result/dispatch routing
    localparam int CORE_DATA_WIDTH = 32;
    // Default destination select width (2**3 = 8 channels)
    localparam int CORE_SEL_WIDTH  = 3;

    // One-entry output slot occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // A slot can take a new payload if it is empty or being drained this cycle
    function automatic logic slot_can_load(input slot_state_t st, input logic rdy);
        return (st == SLOT_EMPTY) || rdy;
    endfunction

endpackage

// File: rtl/demux1to8_slot.sv
// One-entry output register for a single demux channel: EMPTY/FULL flag plus payload.
// A load while draining replaces the payload with no bubble; data is frozen while
// the consumer stalls. Valid is purely registered so it never depends on rdy.
module demux1to8_slot
    import demux1to8_pkg::*;
#(
    parameter int DATA_WIDTH = CORE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rdy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  room
);

    slot_state_t           state, state_nxt;
    logic [DATA_WIDTH-1:0] data_q;

    // State register; reset discards any held payload
    always_ff @(posedge clk) begin
        if (rst) state <= SLOT_EMPTY;
        else     state <= state_nxt;
    end

    // Payload register; only a load changes it, so an empty slot keeps its last value
    always_ff @(posedge clk) begin
        if (rst)       data_q <= '0;
        else if (load) data_q <= din;
    end

    // Next state: load wins over drain so drain+load stays FULL
    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (load)     state_nxt = SLOT_FULL;
            SLOT_FULL:  if (load)     state_nxt = SLOT_FULL;
                        else if (rdy) state_nxt = SLOT_EMPTY;
            default:                  state_nxt = SLOT_EMPTY;
        endcase
    end

    // Outputs: valid from state only; room is the combinational accept hint
    always_comb begin
        valid = (state == SLOT_FULL);
        dout  = data_q;
        room  = slot_can_load(state, rdy);
    end

endmodule

// File: rtl/demux1to8.sv
// 1-to-N registered dispatcher: one valid/ready stream steered by i_sel to one of
// NUM_OUT channels, each with its own one-entry slot and independent back-pressure.
// o_ready is combinational from i_sel/i_ready through the addressed slot's room.
module demux1to8
    import demux1to8_pkg::*;
#(
    parameter  int DATA_WIDTH = CORE_DATA_WIDTH,
    parameter  int SEL_WIDTH  = CORE_SEL_WIDTH,
    localparam int NUM_OUT    = 2 ** SEL_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_valid,
    input  logic [SEL_WIDTH-1:0]                i_sel,
    input  logic [DATA_WIDTH-1:0]               i_data,
    output logic                                o_ready,
    output logic [NUM_OUT-1:0]                  o_valid,
    output logic [NUM_OUT-1:0][DATA_WIDTH-1:0]  o_data,
    input  logic [NUM_OUT-1:0]                  i_ready,
    output logic                                o_busy
);

    logic [NUM_OUT-1:0] room;
    logic [NUM_OUT-1:0] load;
    logic               accept;

    // Accept handshake toward the producer
    always_comb begin
        o_ready = room[i_sel];
        accept  = i_valid && o_ready;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_slot
            // Select decode: only the addressed channel sees a load
            assign load[g] = accept && (i_sel == SEL_WIDTH'(g));

            demux1to8_slot #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk   (clk),
                .rst   (rst),
                .load  (load[g]),
                .din   (i_data),
                .rdy   (i_ready[g]),
                .valid (o_valid[g]),
                .dout  (o_data[g]),
                .room  (room[g])
            );
        end
    endgenerate

    // Busy whenever any slot holds unconsumed data (register-derived only)
    always_comb begin
        o_busy = |o_valid;
    end

endmodule

// File: tb/tb_demux1to8.sv
// Self-checking bench for demux1to8: directed spec scenarios plus random traffic,
// with a per-cycle reference model feeding an expected-result queue.
module tb_demux1to8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic [2:0]        i_sel;
    logic [31:0]       i_data;
    logic              o_ready;
    logic [7:0]        o_valid;
    logic [7:0][31:0]  o_data;
    logic [7:0]        i_ready;
    logic              o_busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]       v;
        logic [7:0][31:0] d;
    } exp_t;
    exp_t q[$];

    logic [7:0]       mfull = '0;
    logic [7:0][31:0] mdata = '0;
    logic             rdy_seen;

    demux1to8 dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_sel   (i_sel),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check o_ready against the model, advance the
    // model, push its expectation, then pop and compare after the rising edge.
    task automatic cyc(input logic r, input logic v, input logic [2:0] s,
                       input logic [31:0] d, input logic [7:0] rdy);
        logic  mready;
        exp_t  e, got;
        @(negedge clk);
        rst = r; i_valid = v; i_sel = s; i_data = d; i_ready = rdy;
        #1;
        mready   = !mfull[s] || rdy[s];
        rdy_seen = o_ready;
        if (!r) chk("o_ready", {255'b0, o_ready}, {255'b0, mready});
        for (int ch = 0; ch < 8; ch++) begin
            if (r) begin
                mfull[ch] = 1'b0;
                mdata[ch] = '0;
            end else if (v && mready && s == 3'(ch)) begin
                mfull[ch] = 1'b1;
                mdata[ch] = d;
            end else if (mfull[ch] && rdy[ch]) begin
                mfull[ch] = 1'b0;
            end
        end
        e.v = mfull;
        e.d = mdata;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("o_valid", {248'b0, o_valid}, {248'b0, got.v});
        chk("o_data",  o_data, got.d);
        chk("o_busy",  {255'b0, o_busy}, {255'b0, |got.v});
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_sel = '0; i_data = '0; i_ready = '0;

        // Reset held two cycles
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        chk("rst_valid", {248'b0, o_valid}, 256'h0);
        chk("rst_busy",  {255'b0, o_busy},  256'h0);
        chk("rst_ready", {255'b0, o_ready}, 256'h1);
        chk("rst_data",  o_data, 256'h0);

        // Single transfer to ch5, held while stalled, then drained
        cyc(0, 1, 5, 32'hDEADBEEF, 8'h00);
        chk("single_valid", {248'b0, o_valid}, 256'h20);
        chk("single_data",  {224'b0, o_data[5]}, 256'hDEADBEEF);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 8'h00);
        chk("single_hold", {224'b0, o_data[5]}, 256'hDEADBEEF);
        cyc(0, 0, 0, 0, 8'h20);
        chk("single_drain", {248'b0, o_valid}, 256'h0);

        // Back-pressure on ch2, then redirect to ch3
        cyc(0, 1, 2, 32'h0000_0022, 8'h00);
        cyc(0, 1, 2, 32'h0000_0099, 8'h00);
        chk("bp_ready", {255'b0, rdy_seen}, 256'h0);
        chk("bp_data",  {224'b0, o_data[2]}, 256'h22);
        cyc(0, 1, 3, 32'h0000_0033, 8'h00);
        chk("bp_redirect_ready", {255'b0, rdy_seen}, 256'h1);
        chk("bp_ch3_valid", {255'b0, o_valid[3]}, 256'h1);
        cyc(0, 0, 0, 0, 8'hFF);

        // Drain + load same cycle on ch7
        cyc(0, 1, 7, 32'hAAAA_AAAA, 8'h00);
        cyc(0, 1, 7, 32'hBBBB_BBBB, 8'h80);
        chk("dl_ready", {255'b0, rdy_seen}, 256'h1);
        chk("dl_valid", {255'b0, o_valid[7]}, 256'h1);
        chk("dl_data",  {224'b0, o_data[7]}, 256'hBBBB_BBBB);
        cyc(0, 0, 0, 0, 8'hFF);

        // Streaming 0..7 with all consumers ready
        for (int s = 0; s < 8; s++) begin
            cyc(0, 1, 3'(s), 32'(s + 1), 8'hFF);
            chk("stream_onehot", {248'b0, o_valid}, {248'b0, 8'(1 << s)});
            chk("stream_data",   {224'b0, o_data[s]}, {224'b0, 32'(s + 1)});
        end
        cyc(0, 0, 0, 0, 8'hFF);
        chk("stream_end", {248'b0, o_valid}, 256'h0);

        // Fill all channels, then reset mid-operation
        for (int s = 0; s < 8; s++) cyc(0, 1, 3'(s), 32'h100 + 32'(s), 8'h00);
        chk("fill_valid", {248'b0, o_valid}, 256'hFF);
        chk("fill_busy",  {255'b0, o_busy},  256'h1);
        cyc(1, 1, 0, 32'h1234, 8'h00);
        chk("midrst_valid", {248'b0, o_valid}, 256'h0);
        chk("midrst_busy",  {255'b0, o_busy},  256'h0);
        chk("midrst_data",  o_data, 256'h0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom), 3'($urandom),
                $urandom, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
